// File: rtl/ysyx_23060184_hazard_scoreboard_pkg.sv
// ysyx_23060184_hazard_scoreboard_pkg: shared forwarding encodings and redirect FSM states
package ysyx_23060184_hazard_scoreboard_pkg;
  localparam int FWD_WIDTH = 2;
  localparam logic [FWD_WIDTH-1:0] FWD_RF = 2'd0;
  localparam logic [FWD_WIDTH-1:0] FWD_M = 2'd1;
  localparam logic [FWD_WIDTH-1:0] FWD_W = 2'd2;
  typedef enum logic {RDR_IDLE = 1'b0, RDR_WAIT = 1'b1} rdr_state_t;
endpackage

// File: rtl/ysyx_23060184_reg_scoreboard.sv
// ysyx_23060184_reg_scoreboard: per-register pending-load bits with an inflight counter
module ysyx_23060184_reg_scoreboard
  import ysyx_23060184_hazard_scoreboard_pkg::*;
#(
  parameter int NR_REGS = 32,
  parameter int REG_W = 5,
  parameter int MAX_INFLIGHT = 2,
  localparam int IF_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_valid,
  input  logic [REG_W-1:0] set_rd,
  input  logic             clr_valid,
  input  logic [REG_W-1:0] clr_rd,
  input  logic [REG_W-1:0] look_a,
  input  logic [REG_W-1:0] look_b,
  output logic             pend_a,
  output logic             pend_b,
  output logic             full
);
  logic [NR_REGS-1:0] pend;
  logic [IF_W-1:0] inflight;
  logic set, clr;
  assign set = set_valid & (set_rd != '0);
  assign clr = clr_valid & pend[clr_rd];
  assign pend_a = pend[look_a];
  assign pend_b = pend[look_b];
  assign full = inflight == IF_W'(MAX_INFLIGHT);
  // clear first so a same-register set in the same cycle wins; the +1/-1 then cancel
  always_ff @(posedge clock) begin
    if (reset) begin
      pend <= '0;
      inflight <= '0;
    end else begin
      if (clr) pend[clr_rd] <= 1'b0;
      if (set) pend[set_rd] <= 1'b1;
      inflight <= inflight + IF_W'(set) - IF_W'(clr);
    end
  end
endmodule

// File: rtl/ysyx_23060184_hazard_scoreboard.sv
// ysyx_23060184_hazard_scoreboard: load-use/capacity stalls, forwarding and redirect flush control
module ysyx_23060184_hazard_scoreboard
  import ysyx_23060184_hazard_scoreboard_pkg::*;
#(
  parameter int NR_REGS = 32,
  parameter int REG_W = 5,
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [REG_W-1:0]     rs1_d,
  input  logic [REG_W-1:0]     rs2_d,
  input  logic                 rs2_d_valid,
  input  logic [REG_W-1:0]     rs1_e,
  input  logic [REG_W-1:0]     rs2_e,
  input  logic [REG_W-1:0]     rd_e,
  input  logic                 load_e,
  input  logic                 issue_e,
  input  logic [REG_W-1:0]     rd_m,
  input  logic                 reg_write_m,
  input  logic [REG_W-1:0]     rd_w,
  input  logic                 reg_write_w,
  input  logic                 lsu_resp_valid,
  input  logic [REG_W-1:0]     lsu_resp_rd,
  input  logic                 redirect_e,
  input  logic                 ifu_redirect_ready,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 stall_e,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic [FWD_WIDTH-1:0] fwd_a_e,
  output logic [FWD_WIDTH-1:0] fwd_b_e,
  output logic                 sb_full,
  output logic [CNT_W-1:0]     load_stall_cnt
);
  rdr_state_t state;
  logic pend_a, pend_b, hit_a, hit_b, luse, cap, active;
  ysyx_23060184_reg_scoreboard #(
    .NR_REGS(NR_REGS), .REG_W(REG_W), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_sb (
    .clock(clock), .reset(reset),
    .set_valid(load_e & issue_e), .set_rd(rd_e),
    .clr_valid(lsu_resp_valid), .clr_rd(lsu_resp_rd),
    .look_a(rs1_d), .look_b(rs2_d),
    .pend_a(pend_a), .pend_b(pend_b), .full(sb_full)
  );
  function automatic logic [FWD_WIDTH-1:0] fwd_sel(input logic [REG_W-1:0] rs);
    return (reg_write_m & rs != '0 & rs == rd_m) ? FWD_M :
           (reg_write_w & rs != '0 & rs == rd_w) ? FWD_W : FWD_RF;
  endfunction
  // the load_e term covers the issue cycle, before the pending bit is registered
  always_comb begin
    active = redirect_e | (state == RDR_WAIT);
    hit_a = (rs1_d != '0) & (pend_a | (load_e & rd_e == rs1_d));
    hit_b = (rs2_d != '0) & (pend_b | (load_e & rd_e == rs2_d));
    luse = ~active & (hit_a | (rs2_d_valid & hit_b));
    cap = load_e & sb_full & ~lsu_resp_valid;
    stall_f = active ? ~ifu_redirect_ready : (luse | cap);
    stall_d = ~active & (luse | cap);
    stall_e = cap;
    flush_d = active;
    flush_e = active | (luse & ~cap);
    fwd_a_e = fwd_sel(rs1_e);
    fwd_b_e = fwd_sel(rs2_e);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RDR_IDLE;
      load_stall_cnt <= '0;
    end else begin
      state <= (state == RDR_IDLE) ? ((redirect_e & ~ifu_redirect_ready) ? RDR_WAIT : RDR_IDLE)
                                   : (ifu_redirect_ready ? RDR_IDLE : RDR_WAIT);
      if (luse & ~&load_stall_cnt) load_stall_cnt <= load_stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ysyx_23060184_hazard_scoreboard.sv
// tb_ysyx_23060184_hazard_scoreboard: directed stimulus checked against a per-cycle behavioural model
module tb_ysyx_23060184_hazard_scoreboard;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic clk, reset;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, lsu_resp_rd;
  logic rs2_d_valid, load_e, issue_e, reg_write_m, reg_write_w, lsu_resp_valid;
  logic redirect_e, ifu_redirect_ready;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, sb_full;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [CNT_W-1:0] load_stall_cnt;
  int tests = 0, fails = 0;
  bit [31:0] m_pend;
  int m_inflight, m_cnt;
  bit m_wait, m_ok = 0;

  ysyx_23060184_hazard_scoreboard #(.NR_REGS(32), .REG_W(5), .MAX_INFLIGHT(2), .CNT_W(CNT_W)) dut (
    .clock(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs2_d_valid(rs2_d_valid),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .load_e(load_e), .issue_e(issue_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rd(lsu_resp_rd), .redirect_e(redirect_e),
    .ifu_redirect_ready(ifu_redirect_ready), .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .flush_d(flush_d), .flush_e(flush_e), .fwd_a_e(fwd_a_e),
    .fwd_b_e(fwd_b_e), .sb_full(sb_full), .load_stall_cnt(load_stall_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [4:0] r);
    return r != 0 && (m_pend[r] || (load_e && rd_e == r));
  endfunction
  function automatic bit m_active();
    return redirect_e || m_wait;
  endfunction
  function automatic bit m_luse();
    return !m_active() && (m_hit(rs1_d) || (rs2_d_valid && m_hit(rs2_d)));
  endfunction
  function automatic bit m_cap();
    return load_e && m_inflight == 2 && !lsu_resp_valid;
  endfunction
  function automatic int m_fwd(input logic [4:0] rs);
    if (rs != 0 && reg_write_m && rs == rd_m) return 1;
    if (rs != 0 && reg_write_w && rs == rd_w) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pend <= '0;
      m_inflight <= 0;
      m_wait <= 0;
      m_cnt <= 0;
      m_ok <= 1;
    end else begin
      if (m_luse() && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      m_wait <= m_wait ? !ifu_redirect_ready : (redirect_e && !ifu_redirect_ready);
      if (lsu_resp_valid && m_pend[lsu_resp_rd]) m_pend[lsu_resp_rd] <= 0;
      if (load_e && issue_e && rd_e != 0) m_pend[rd_e] <= 1;
      m_inflight <= m_inflight + int'(load_e && issue_e && rd_e != 0)
                                - int'(lsu_resp_valid && m_pend[lsu_resp_rd]);
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("stall_f", stall_f, m_active() ? !ifu_redirect_ready : (m_luse() || m_cap()));
      chk("stall_d", stall_d, !m_active() && (m_luse() || m_cap()));
      chk("stall_e", stall_e, m_cap());
      chk("flush_d", flush_d, m_active());
      chk("flush_e", flush_e, m_active() || (m_luse() && !m_cap()));
      chk("fwd_a_e", fwd_a_e, m_fwd(rs1_e));
      chk("fwd_b_e", fwd_b_e, m_fwd(rs2_e));
      chk("sb_full", sb_full, m_inflight == 2);
      chk("load_stall_cnt", load_stall_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] r);
    load_e = 1; issue_e = 1; rd_e = r;
  endtask

  initial begin
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, lsu_resp_rd} = '0;
    {rs2_d_valid, load_e, issue_e, reg_write_m, reg_write_w, lsu_resp_valid} = '0;
    {redirect_e, ifu_redirect_ready} = '0;
    reset = 1;
    tick(); tick();
    reset = 0; #1;
    chk("rst_outs", {stall_f, stall_d, stall_e, flush_d, flush_e, fwd_a_e, fwd_b_e, sb_full}, 0);
    chk("rst_cnt", load_stall_cnt, 0);
    // load-use: lw x5 then consumer in D, response three cycles after issue
    tick(); load(5); rs1_d = 5; rs2_d = 1; rs2_d_valid = 1; #1;
    chk("t1_issue_stall_d", stall_d, 1);
    chk("t1_issue_flush_e", flush_e, 1);
    tick(); load_e = 0; issue_e = 0; rd_e = 0; #1;
    chk("t1_c1_stall_f", stall_f, 1);
    tick(); #1;
    chk("t1_c2_stall_d", stall_d, 1);
    tick(); lsu_resp_valid = 1; lsu_resp_rd = 5; #1;
    chk("t1_resp_stall_d", stall_d, 1);
    tick(); lsu_resp_valid = 0; #1;
    chk("t1_after_stall_d", stall_d, 0);
    chk("t1_cnt", load_stall_cnt, 4);
    rs1_d = 0; rs2_d_valid = 0;
    // forwarding priority
    tick(); rd_m = 7; rd_w = 7; reg_write_m = 1; reg_write_w = 1; rs1_e = 7; rs2_e = 7; #1;
    chk("t2_fwd_m", fwd_a_e, 1);
    tick(); reg_write_m = 0; #1;
    chk("t2_fwd_w", fwd_a_e, 2);
    tick(); rs1_e = 0; #1;
    chk("t2_fwd_x0", fwd_a_e, 0);
    chk("t2_fwd_b_w", fwd_b_e, 2);
    tick(); {rd_m, rd_w, rs2_e, reg_write_w} = '0;
    // capacity
    load(3);
    tick(); load(4);
    tick(); rd_e = 8; issue_e = 0; #1;
    chk("t3_full", sb_full, 1);
    chk("t3_stall_e", stall_e, 1);
    tick(); lsu_resp_valid = 1; lsu_resp_rd = 3; issue_e = 1; #1;
    chk("t3_resp_stall_e", stall_e, 0);
    tick(); load_e = 0; issue_e = 0; rd_e = 0; lsu_resp_valid = 0; #1;
    chk("t3_still_full", sb_full, 1);
    tick(); lsu_resp_valid = 1; lsu_resp_rd = 4;
    tick(); lsu_resp_valid = 0;
    // redirect with x8 pending in D
    rs1_d = 8; redirect_e = 1; ifu_redirect_ready = 0; #1;
    chk("t4_c0_flush_d", flush_d, 1);
    chk("t4_c0_flush_e", flush_e, 1);
    chk("t4_c0_stall_f", stall_f, 1);
    chk("t4_c0_stall_d", stall_d, 0);
    tick(); redirect_e = 0; #1;
    chk("t4_c1_flush_d", flush_d, 1);
    chk("t4_c1_stall_f", stall_f, 1);
    chk("t4_c1_stall_d", stall_d, 0);
    tick(); ifu_redirect_ready = 1; #1;
    chk("t4_c2_flush_d", flush_d, 1);
    chk("t4_c2_stall_f", stall_f, 0);
    tick(); ifu_redirect_ready = 0; #1;
    chk("t4_idle_flush_d", flush_d, 0);
    chk("t4_cnt_masked", load_stall_cnt, 4);
    chk("t4_unmasked_stall_d", stall_d, 1);
    tick(); #1;
    chk("t4_cnt_inc", load_stall_cnt, 5);
    rs1_d = 0; lsu_resp_valid = 1; lsu_resp_rd = 8;
    tick(); lsu_resp_valid = 0;
    // same-reg set/clear, stray response
    load(9);
    tick(); lsu_resp_valid = 1; lsu_resp_rd = 9;
    tick(); load_e = 0; issue_e = 0; rd_e = 0; lsu_resp_valid = 0; rs1_d = 9; #1;
    chk("t5_pend9", stall_d, 1);
    chk("t5_not_full", sb_full, 0);
    lsu_resp_valid = 1; lsu_resp_rd = 12;
    tick(); lsu_resp_valid = 0; load(10);
    tick(); load_e = 0; issue_e = 0; rd_e = 0; #1;
    chk("t5_full_after_stray", sb_full, 1);
    repeat (16) tick();
    chk("cnt_saturated", load_stall_cnt, CNT_MAX);
    // reset with two loads outstanding
    reset = 1;
    tick(); reset = 0; #1;
    chk("t6_full", sb_full, 0);
    chk("t6_cnt", load_stall_cnt, 0);
    chk("t6_stall_d", stall_d, 0);
    lsu_resp_valid = 1; lsu_resp_rd = 9;
    tick(); lsu_resp_rd = 10; #1;
    chk("t6_late_stall_d", stall_d, 0);
    tick(); lsu_resp_valid = 0; rs1_d = 0; load(3);
    tick(); rd_e = 4;
    tick(); load_e = 0; issue_e = 0; rd_e = 0; #1;
    chk("t6_no_underflow", sb_full, 1);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
